// File: rtl/ccp_pkg.sv
// Shared types and constants for the CCP two-wire symbol link.
package ccp_pkg;

    // Receiver control states.
    typedef enum logic [1:0] {
        WAIT_ZERO = 2'd0,
        ARMED     = 2'd1,
        GAP       = 2'd2
    } ccp_state_e;

    // Legacy-compatible state encodings used by the FSM register.
    localparam logic [1:0] ST_WAIT_ZERO = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_GAP       = 2'd2;

    // Sample classes, packed as {signalA, signalB}.
    localparam logic [1:0] CCP_IDLE = 2'b00;
    localparam logic [1:0] CCP_SYM0 = 2'b10;
    localparam logic [1:0] CCP_SYM1 = 2'b01;
    localparam logic [1:0] CCP_BOTH = 2'b11;

    // Bit value carried by each symbol line.
    localparam logic SYM_A_BIT = 1'b0;
    localparam logic SYM_B_BIT = 1'b1;

    // Map a symbol class to its data bit.
    function automatic logic class_to_bit(input logic [1:0] cls);
        return (cls == CCP_SYM1) ? SYM_B_BIT : SYM_A_BIT;
    endfunction

endpackage

// File: rtl/ccp_sync_debounce.sv
// Two-flop synchronizers on both CCP lines plus a class-stability counter.
// The class is stable once HOLD_CYCLES consecutive identical samples are seen;
// stable_new marks the single cycle in which a class first becomes stable.
module ccp_sync_debounce
    import ccp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_a,
    input  logic       line_b,
    input  logic       clear,
    output logic [1:0] cls,
    output logic       stable,
    output logic       stable_new
);

    localparam int unsigned CW = 4;

    logic           a_s1;
    logic           a_s2;
    logic           b_s1;
    logic           b_s2;
    logic [1:0]     prev_cls;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           changed;

    // Synchronize both asynchronous lines into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= line_a;
            a_s2 <= a_s1;
            b_s1 <= line_b;
            b_s2 <= b_s1;
        end
    end

    // Count consecutive identical samples, saturating at HOLD_CYCLES.
    always_comb begin
        cls     = {a_s2, b_s2};
        changed = (cls != prev_cls);
        cnt_nxt = cnt;
        if (changed) begin
            cnt_nxt = CW'(1);
        end else if (cnt < CW'(HOLD_CYCLES)) begin
            cnt_nxt = cnt + CW'(1);
        end
        stable     = (cnt_nxt == CW'(HOLD_CYCLES));
        stable_new = stable && (changed || (cnt != CW'(HOLD_CYCLES)));
    end

    // Stability state; clear forces a full re-qualification of the current class.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_cls <= CCP_IDLE;
            cnt      <= '0;
        end else if (clear) begin
            prev_cls <= cls;
            cnt      <= '0;
        end else begin
            prev_cls <= cls;
            cnt      <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ccp_receiver.sv
// CCP link receiver: accepts return-to-zero symbols on signalA/signalB,
// assembles them LSB-first into words and reports link errors.
module ccp_receiver
    import ccp_pkg::*;
#(
    parameter int unsigned WORD_W         = 8,
    parameter int unsigned HOLD_CYCLES    = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              signalA,
    input  logic              signalB,
    output logic              readySignal,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic [7:0]        err_count
);

    localparam int unsigned BW = $clog2(WORD_W + 1);
    localparam int unsigned GW = 8;
    localparam int unsigned TW = 16;

    logic [1:0]        cls;
    logic              stable;
    logic              stable_new;
    logic              gap_entry;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [WORD_W-1:0] shreg_bit;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_cnt_nxt;
    logic [TW-1:0]     idle_cnt;
    logic [TW-1:0]     idle_cnt_nxt;
    logic              ready_nxt;
    logic [WORD_W-1:0] data_out_nxt;
    logic              data_valid_nxt;
    logic              err_illegal_nxt;
    logic              err_timeout_nxt;
    logic [7:0]        err_count_nxt;
    logic              accept;
    logic              err_any;

    ccp_sync_debounce #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_sync_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_a    (signalA),
        .line_b    (signalB),
        .clear     (gap_entry),
        .cls       (cls),
        .stable    (stable),
        .stable_new(stable_new)
    );

    assign gap_entry = accept || err_any;

    // Next-state and next-output logic for the receive FSM and its counters.
    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shreg_nxt       = shreg;
        gap_cnt_nxt     = gap_cnt;
        idle_cnt_nxt    = idle_cnt;
        data_out_nxt    = data_out;
        data_valid_nxt  = 1'b0;
        err_illegal_nxt = 1'b0;
        err_timeout_nxt = 1'b0;
        err_count_nxt   = err_count;
        accept          = 1'b0;
        err_any         = 1'b0;
        shreg_bit       = shreg | (WORD_W'(class_to_bit(cls)) << bit_cnt);

        case (state)
            ST_WAIT_ZERO: begin
                if (stable && (cls == CCP_IDLE)) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (stable_new) begin
                    if ((cls == CCP_SYM0) || (cls == CCP_SYM1)) begin
                        accept      = 1'b1;
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = '0;
                        if (bit_cnt == BW'(WORD_W - 1)) begin
                            data_out_nxt   = shreg_bit;
                            data_valid_nxt = 1'b1;
                            bit_cnt_nxt    = '0;
                            shreg_nxt      = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BW'(1);
                            shreg_nxt   = shreg_bit;
                        end
                    end else if (cls == CCP_BOTH) begin
                        err_any         = 1'b1;
                        err_illegal_nxt = 1'b1;
                        state_nxt       = ST_GAP;
                        gap_cnt_nxt     = '0;
                        bit_cnt_nxt     = '0;
                        shreg_nxt       = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nxt = ST_WAIT_ZERO;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nxt = ST_WAIT_ZERO;
            end
        endcase

        // Partial-word idle timeout; a same-cycle acceptance or error takes priority.
        if (accept || err_any) begin
            idle_cnt_nxt = '0;
        end else if ((bit_cnt != '0) && (state != ST_GAP)) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                err_timeout_nxt = 1'b1;
                bit_cnt_nxt     = '0;
                shreg_nxt       = '0;
                idle_cnt_nxt    = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + TW'(1);
            end
        end

        if ((err_illegal_nxt || err_timeout_nxt) && (err_count != 8'hFF)) begin
            err_count_nxt = err_count + 8'd1;
        end

        ready_nxt = (state_nxt != ST_GAP);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT_ZERO;
            bit_cnt     <= '0;
            shreg       <= '0;
            gap_cnt     <= '0;
            idle_cnt    <= '0;
            readySignal <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shreg       <= shreg_nxt;
            gap_cnt     <= gap_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
            readySignal <= ready_nxt;
            data_out    <= data_out_nxt;
            data_valid  <= data_valid_nxt;
            err_illegal <= err_illegal_nxt;
            err_timeout <= err_timeout_nxt;
            err_count   <= err_count_nxt;
        end
    end

endmodule

// File: tb/tb_ccp_receiver.sv
// Self-checking bench for ccp_receiver: directed and randomized symbol traffic
// checked against a transaction-level model of the link.
module tb_ccp_receiver;

    localparam int GAP     = 4;
    localparam int HOLD    = 3;
    localparam int TIMEOUT = 1000;
    localparam logic [1:0] L_IDLE = 2'b00;
    localparam logic [1:0] L_A    = 2'b10;
    localparam logic [1:0] L_B    = 2'b01;
    localparam logic [1:0] L_BOTH = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       signalA;
    logic       signalB;
    logic       readySignal;
    logic [7:0] data_out;
    logic       data_valid;
    logic       err_illegal;
    logic       err_timeout;
    logic [7:0] err_count;

    ccp_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signalA    (signalA),
        .signalB    (signalB),
        .readySignal(readySignal),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Monitor state
    int          cyc       = 0;
    int          low_run   = 0;
    bit          skip      = 1'b1;
    int          gap_runs  = 0;
    int          gap_bad   = 0;
    int          rise_cyc  = 0;
    int          dv_long   = 0;
    bit          dv_prev   = 1'b0;
    int          ill_cnt   = 0;
    int          to_cnt    = 0;
    int          to_delta  = -1;
    logic [7:0]  got_q[$];

    // Reference model state
    int          m_acc = 0;
    int          m_n   = 0;
    int          m_err = 0;
    logic [7:0]  m_last = 8'h00;
    logic [7:0]  exp_q[$];

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            skip    = 1'b1;
            low_run = 0;
            dv_prev = 1'b0;
        end else begin
            if (data_valid) begin
                got_q.push_back(data_out);
                if (dv_prev) dv_long++;
            end
            dv_prev = data_valid;
            if (err_illegal) ill_cnt++;
            if (err_timeout) begin
                to_cnt++;
                to_delta = cyc - rise_cyc;
            end
            if (!readySignal) begin
                low_run++;
            end else if (low_run != 0) begin
                if (!skip) begin
                    gap_runs++;
                    if (low_run != GAP) gap_bad++;
                end
                skip     = 1'b0;
                rise_cyc = cyc;
                low_run  = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input int n);
        signalA = c[1];
        signalB = c[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!readySignal && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            fails++;
            $error("FAIL ready_wait observed=0 expected=1");
        end
    endtask

    // Model of one accepted symbol on the link.
    task automatic model_symbol(input logic [1:0] c);
        if (c == L_BOTH) begin
            m_acc = 0;
            m_n   = 0;
            if (m_err < 255) m_err++;
        end else begin
            m_acc = m_acc + ((c == L_B) ? (1 << m_n) : 0);
            m_n++;
            if (m_n == 8) begin
                m_last = 8'(m_acc);
                exp_q.push_back(m_last);
                m_acc = 0;
                m_n   = 0;
            end
        end
    endtask

    task automatic send_sym(input logic [1:0] c, input int hold, input int idle);
        wait_ready();
        @(negedge clk);
        drive(c, hold);
        drive(L_IDLE, idle);
        model_symbol(c);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_sym(v[i] ? L_B : L_A, 5, 5);
        end
    endtask

    task automatic glitch(input logic [1:0] c, input int len);
        wait_ready();
        @(negedge clk);
        drive(c, len);
        drive(L_IDLE, 6);
    endtask

    task automatic check_words(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   readySignal, 0);
        check({tag, "_data"},    data_out,    0);
        check({tag, "_dv"},      data_valid,  0);
        check({tag, "_ill"},     err_illegal, 0);
        check({tag, "_to"},      err_timeout, 0);
        check({tag, "_errcnt"},  err_count,   0);
    endtask

    initial begin
        int snap;
        int t;
        logic [7:0] v;

        // Reset with lines low
        rst_n   = 1'b0;
        signalA = 1'b0;
        signalB = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_ready", readySignal, 1);
        check("post_reset_dv", got_q.size(), 0);
        check("post_reset_errcnt", err_count, 0);

        // 0xA5 LSB-first
        snap = gap_runs;
        send_byte(8'hA5);
        check_words("a5");
        check("a5_data_out", data_out, 8'hA5);
        check("a5_gap_runs", gap_runs - snap, 8);
        check("a5_gap_len_bad", gap_bad, 0);
        check("a5_dv_single", dv_long, 0);

        // Sub-HOLD glitch is ignored
        snap = gap_runs;
        glitch(L_A, 2);
        check("glitch_no_accept", gap_runs - snap, 0);
        check("glitch_ready", readySignal, 1);

        // Three bits, then illegal BOTH, then a clean byte
        for (int i = 0; i < 3; i++) send_sym(($urandom_range(0, 1) != 0) ? L_B : L_A, 5, 5);
        send_sym(L_BOTH, 5, 5);
        check("illegal_pulse", ill_cnt, 1);
        check("illegal_errcnt", err_count, m_err);
        v = 8'($urandom_range(0, 255));
        send_byte(v);
        check_words("after_illegal");
        check("after_illegal_data", data_out, v);

        // Two bits then idle until the partial word times out
        send_sym(L_B, 5, 5);
        send_sym(L_A, 5, 5);
        t = 0;
        while (to_cnt == 0 && t < 1300) begin
            @(negedge clk);
            t++;
        end
        check("timeout_pulse", to_cnt, 1);
        check("timeout_delay", to_delta, TIMEOUT);
        m_acc = 0;
        m_n   = 0;
        m_err++;
        check("timeout_errcnt", err_count, m_err);
        send_byte(8'h3C);
        check_words("after_timeout");
        check("after_timeout_data", data_out, 8'h3C);

        // Randomized traffic with glitches and occasional illegal symbols
        for (int w = 0; w < 6; w++) begin
            v = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 4) == 0)
                    glitch(2'($urandom_range(1, 3)), $urandom_range(1, HOLD - 1));
                if ($urandom_range(0, 24) == 0)
                    send_sym(L_BOTH, $urandom_range(4, 7), $urandom_range(5, 8));
                send_sym(v[i] ? L_B : L_A, $urandom_range(4, 7), $urandom_range(5, 8));
            end
        end
        check_words("random");
        check("random_data_out", data_out, m_last);
        check("random_errcnt", err_count, m_err);
        check("random_gap_len_bad", gap_bad, 0);

        // Reset in the middle of a gap after five bits
        for (int i = 0; i < 4; i++) send_sym(L_B, 5, 5);
        wait_ready();
        @(negedge clk);
        signalA = 1'b1;
        t = 0;
        while (readySignal && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("midgap_ready_low", readySignal, 0);
        rst_n   = 1'b0;
        signalA = 1'b0;
        signalB = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midgap_reset");
        rst_n = 1'b1;
        m_acc = 0;
        m_n   = 0;
        m_err = 0;
        got_q.delete();
        exp_q.delete();
        repeat (6) @(negedge clk);
        send_byte(8'hFF);
        check_words("after_reset");
        check("after_reset_data", data_out, 8'hFF);
        check("after_reset_errcnt", err_count, 0);

        // err_count saturates at 255
        for (int i = 0; i < 260; i++) send_sym(L_BOTH, 4, 5);
        check("saturate_errcnt", err_count, 255);
        check("saturate_model", m_err, 255);
        send_byte(8'h5A);
        check_words("after_saturate");
        check("after_saturate_data", data_out, 8'h5A);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ccp_receiver.md
Name: ccp_receiver

Overview:
- Receive end of the two-wire CCP symbol link. It models the peer that samples signalA/signalB and drives readySignal back to the CCP transmitter.
- Each accepted symbol is one bit: signalA = 0, signalB = 1. Bits are assembled LSB-first into WORD_W-bit words.
- Used for FPGA-to-FPGA loopback and board test of the CCP link, and as the receive side on boards that have no Arduino.

Parameters:
- WORD_W, 8, bits per assembled word (2..16).
- HOLD_CYCLES, 3, consecutive identical synchronized samples needed to accept a level (1..15).
- GAP_CYCLES, 4, cycles readySignal is held low after each accepted symbol (1..255).
- TIMEOUT_CYCLES, 1000, idle cycles allowed in a partial word before it is discarded (16..65535).

Ports:
- clk  in  1  system clock, ms-order tick, same clock as the transmitter.
- rst_n  in  1  synchronous active-low reset.
- signalA  in  1  symbol-0 line from the transmitter; asynchronous-safe.
- signalB  in  1  symbol-1 line from the transmitter.
- readySignal  out  1  high when the receiver will accept a new symbol.
- data_out  out  WORD_W  last completed word.
- data_valid  out  1  one-cycle pulse when data_out updates.
- err_illegal  out  1  one-cycle pulse when both lines are high and stable.
- err_timeout  out  1  one-cycle pulse when a partial word is discarded.
- err_count  out  8  saturating count of all errors (illegal + timeout).

Behaviour:
- Reset (rst_n=0 at posedge clk) forces: readySignal=0, data_out=0, data_valid=0, err_illegal=0, err_timeout=0, err_count=0, bit_cnt=0, shift register 0, synchronizers 0, state WAIT_ZERO. Reset applies mid-word and mid-gap with no residue.
- signalA and signalB each pass a 2-flop synchronizer, then a debouncer. A sample class (IDLE=00, A=10, B=01, BOTH=11) is stable once HOLD_CYCLES consecutive identical samples are seen. Any change of class restarts the count.
- Minimum latency from a line edge to the acceptance state change is 2 + HOLD_CYCLES clocks.
- States:
  - WAIT_ZERO: readySignal=1. Stable IDLE goes to ARMED. The link is return-to-zero: no symbol is accepted until both lines are low.
  - ARMED: readySignal=1.
    - Stable A or B: shift the bit into position bit_cnt, bit_cnt++, go to GAP.
    - Stable BOTH: err_illegal pulse, err_count++, bit_cnt=0, shift register cleared, go to GAP.
  - GAP: readySignal=0 for exactly GAP_CYCLES clocks, then WAIT_ZERO. The debouncer count is cleared on entry.
- readySignal is registered. It falls in the cycle after acceptance and rises in the cycle after GAP ends.
- Word completion: when the accepted bit makes bit_cnt reach WORD_W:
  - data_out is loaded with the full word.
  - data_valid pulses in the same cycle data_out changes, one clock after the acceptance edge.
  - bit_cnt wraps to 0.
  - data_out holds until the next completed word.
- Timeout: the idle counter runs only while bit_cnt != 0 and the state is WAIT_ZERO or ARMED. It clears on every accepted symbol and on any error.
  - On reaching TIMEOUT_CYCLES: err_timeout pulse, err_count++, bit_cnt=0, shift register cleared. The state is unchanged.
  - If a symbol is accepted in the same cycle the timeout would fire, the acceptance wins and no timeout is raised.
- err_count saturates at 255 and never wraps. It clears only on reset.
- Stable BOTH seen in WAIT_ZERO does not raise an error. The receiver simply keeps waiting for IDLE.

Decomposition:
- Shared package ccp_pkg:
  - state enum {WAIT_ZERO, ARMED, GAP};
  - sample-class constants CCP_IDLE, CCP_SYM0, CCP_SYM1, CCP_BOTH;
  - symbol-to-bit mapping constants SYM_A_BIT=0, SYM_B_BIT=1.
- One sub-module, ccp_sync_debounce:
  - contains both 2-flop synchronizers and the HOLD_CYCLES class-stability counter;
  - outputs the stable class and a one-cycle stable_new strobe;
  - takes a clear input, driven by GAP entry.

Test Plan (defaults: WORD_W=8, HOLD=3, GAP=4, TIMEOUT=1000):
- Reset release, lines low → readySignal=1 within 6 clocks, no outputs toggle, err_count=0.
- Send 0xA5 LSB-first (B,A,B,A,A,B,A,B), each symbol held 5 clocks then both low 5 clocks while honouring ready → single data_valid pulse, data_out=0xA5, readySignal low exactly 4 clocks after each symbol.
- signalA pulse of 2 clocks (below HOLD) → no acceptance, readySignal stays 1, bit_cnt unchanged.
- Three valid bits, then signalA=signalB=1 for 5 clocks → err_illegal pulse, err_count=1. The following 8 clean symbols yield a correct word with no stale bits.
- Two bits, then lines idle for 1000 clocks → err_timeout pulse at cycle 1000, err_count increments. The next full byte 0x3C is received correctly.
- Assert rst_n=0 mid-GAP after 5 bits → all outputs return to reset values. After release, 0xFF is received cleanly.
